// File: rtl/reservation_station_pkg.sv
// ---------------------------------------------------------------------------
// reservation_station_pkg
//
// Shared widths, the stored-entry layout and the operand resolve helper used
// by the reservation station and its priority encoder.
//
// Contents:
//   - field widths for opcode, funct3, data, address and ROB tags
//   - RS_SIZE / RS_IDX_WID and the RS_NONE "no entry found" index
//   - operand_t    : {rdy, val, tag} for one source operand
//   - rs_entry_t   : one reservation station slot
//   - resolve_operand : captures a broadcast value into a waiting operand
// ---------------------------------------------------------------------------
package reservation_station_pkg;

   localparam int OPCODE_WID  = 7;
   localparam int FUNCT3_WID  = 3;
   localparam int DATA_WID    = 32;
   localparam int ADDR_WID    = 32;
   localparam int ROB_POS_WID = 4;

   localparam int RS_SIZE    = 16;
   localparam int RS_IDX_WID = 4;

   // Index reported alongside found=0; only meaningful together with found.
   localparam logic [RS_IDX_WID-1:0] RS_NONE = '0;

   typedef struct packed {
      logic                   rdy;
      logic [DATA_WID-1:0]    val;
      logic [ROB_POS_WID-1:0] tag;
   } operand_t;

   typedef struct packed {
      logic                   busy;
      logic [OPCODE_WID-1:0]  opcode;
      logic [FUNCT3_WID-1:0]  funct3;
      logic                   funct7;
      logic [DATA_WID-1:0]    imm;
      logic [ADDR_WID-1:0]    pc;
      logic [ROB_POS_WID-1:0] rob_pos;
      operand_t               src1;
      operand_t               src2;
   } rs_entry_t;

   // A waiting operand picks up the value of whichever result bus carries its
   // producer tag. Used both for same-cycle bypass at issue and for wakeup of
   // stored entries, so the two paths can never disagree.
   function automatic operand_t resolve_operand(
      input operand_t               op,
      input logic                   alu_hit,
      input logic [ROB_POS_WID-1:0] alu_tag,
      input logic [DATA_WID-1:0]    alu_val,
      input logic                   lsb_hit,
      input logic [ROB_POS_WID-1:0] lsb_tag,
      input logic [DATA_WID-1:0]    lsb_val
   );
      operand_t res;
      res = op;
      if (!op.rdy) begin
         if (alu_hit && alu_tag == op.tag) begin
            res.rdy = 1'b1;
            res.val = alu_val;
         end else if (lsb_hit && lsb_tag == op.tag) begin
            res.rdy = 1'b1;
            res.val = lsb_val;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/reservation_station_rs_pick.sv
// ---------------------------------------------------------------------------
// rs_pick
//
// Lowest-index priority encoder. Reports whether any request bit is set and
// the index of the lowest one.
//
// Ports:
//   req   in  N  request vector
//   found out 1  at least one request bit set
//   idx   out W  index of lowest set bit (RS_NONE when found=0)
// ---------------------------------------------------------------------------
module rs_pick
   import reservation_station_pkg::*;
#(
   parameter int N = RS_SIZE,
   parameter int W = RS_IDX_WID
) (
   input  logic [N-1:0] req,
   output logic         found,
   output logic [W-1:0] idx
);

   // Scan from the top down so the last match written is the lowest index.
   always_comb begin
      found = 1'b0;
      idx   = W'(RS_NONE);
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = W'(i);
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// ---------------------------------------------------------------------------
// reservation_station
//
// Out-of-order issue buffer in front of the ALU. Holds decoded instructions
// until both operands are known, snooping the ALU and LSB result buses, and
// each cycle dispatches the lowest-index ready entry.
//
// Ports:
//   clk, rst (async, active-low), rdy (global stall), rollback (flush)
//   issue, issue_*          : new instruction from the decoder
//   rs_full                 : no free slot (combinational, from busy bits)
//   alu_result*, lsb_result*: result broadcasts used for wakeup/bypass
//   alu_en, alu_*           : registered dispatch to the ALU
// ---------------------------------------------------------------------------
module reservation_station
   import reservation_station_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic                   rollback,

   input  logic                   issue,
   input  logic [OPCODE_WID-1:0]  issue_opcode,
   input  logic [FUNCT3_WID-1:0]  issue_funct3,
   input  logic                   issue_funct7,
   input  logic                   issue_rs1_rdy,
   input  logic [DATA_WID-1:0]    issue_rs1_val,
   input  logic [ROB_POS_WID-1:0] issue_rs1_rob,
   input  logic                   issue_rs2_rdy,
   input  logic [DATA_WID-1:0]    issue_rs2_val,
   input  logic [ROB_POS_WID-1:0] issue_rs2_rob,
   input  logic [DATA_WID-1:0]    issue_imm,
   input  logic [ADDR_WID-1:0]    issue_pc,
   input  logic [ROB_POS_WID-1:0] issue_rob_pos,
   output logic                   rs_full,

   input  logic                   alu_result,
   input  logic [ROB_POS_WID-1:0] alu_result_rob_pos,
   input  logic [DATA_WID-1:0]    alu_result_val,
   input  logic                   lsb_result,
   input  logic [ROB_POS_WID-1:0] lsb_result_rob_pos,
   input  logic [DATA_WID-1:0]    lsb_result_val,

   output logic                   alu_en,
   output logic [OPCODE_WID-1:0]  alu_opcode,
   output logic [FUNCT3_WID-1:0]  alu_funct3,
   output logic                   alu_funct7,
   output logic [DATA_WID-1:0]    alu_val1,
   output logic [DATA_WID-1:0]    alu_val2,
   output logic [DATA_WID-1:0]    alu_imm,
   output logic [ADDR_WID-1:0]    alu_pc,
   output logic [ROB_POS_WID-1:0] alu_rob_pos
);

   rs_entry_t              entries [RS_SIZE];
   logic [RS_SIZE-1:0]     busy_vec;
   logic [RS_SIZE-1:0]     ready_vec;
   logic                   free_found;
   logic [RS_IDX_WID-1:0]  free_idx;
   logic                   pick_found;
   logic [RS_IDX_WID-1:0]  pick_idx;
   rs_entry_t              issue_entry;

   // Flatten busy/ready state into vectors for the two encoders.
   always_comb begin
      busy_vec  = '0;
      ready_vec = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         busy_vec[i]  = entries[i].busy;
         ready_vec[i] = entries[i].busy & entries[i].src1.rdy & entries[i].src2.rdy;
      end
   end

   rs_pick #(.N(RS_SIZE), .W(RS_IDX_WID)) u_free_pick (
      .req   (~busy_vec),
      .found (free_found),
      .idx   (free_idx)
   );

   rs_pick #(.N(RS_SIZE), .W(RS_IDX_WID)) u_ready_pick (
      .req   (ready_vec),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Fullness looks only at busy bits: a slot being dispatched this cycle
   // is still counted as occupied until the edge.
   assign rs_full = ~free_found;

   // Build the entry to be written for an incoming instruction, folding in
   // any same-cycle broadcast that produces one of its operands.
   always_comb begin
      issue_entry         = '0;
      issue_entry.busy    = 1'b1;
      issue_entry.opcode  = issue_opcode;
      issue_entry.funct3  = issue_funct3;
      issue_entry.funct7  = issue_funct7;
      issue_entry.imm     = issue_imm;
      issue_entry.pc      = issue_pc;
      issue_entry.rob_pos = issue_rob_pos;
      issue_entry.src1    = resolve_operand('{issue_rs1_rdy, issue_rs1_val, issue_rs1_rob},
                                            alu_result, alu_result_rob_pos, alu_result_val,
                                            lsb_result, lsb_result_rob_pos, lsb_result_val);
      issue_entry.src2    = resolve_operand('{issue_rs2_rdy, issue_rs2_val, issue_rs2_rob},
                                            alu_result, alu_result_rob_pos, alu_result_val,
                                            lsb_result, lsb_result_rob_pos, lsb_result_val);
   end

   // Main state update: flush, wakeup, dispatch and issue all happen on the
   // same edge. The picked slot is busy and the issue slot is free, so the
   // dispatch and issue writes never touch the same entry. A picked entry is
   // already fully ready, so wakeup never races with its dispatch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            entries[i] <= '0;
         end
         alu_en      <= 1'b0;
         alu_opcode  <= '0;
         alu_funct3  <= '0;
         alu_funct7  <= 1'b0;
         alu_val1    <= '0;
         alu_val2    <= '0;
         alu_imm     <= '0;
         alu_pc      <= '0;
         alu_rob_pos <= '0;
      end else if (rdy) begin
         if (rollback) begin
            for (int i = 0; i < RS_SIZE; i++) begin
               entries[i].busy <= 1'b0;
            end
            alu_en <= 1'b0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (entries[i].busy) begin
                  entries[i].src1 <= resolve_operand(entries[i].src1,
                                        alu_result, alu_result_rob_pos, alu_result_val,
                                        lsb_result, lsb_result_rob_pos, lsb_result_val);
                  entries[i].src2 <= resolve_operand(entries[i].src2,
                                        alu_result, alu_result_rob_pos, alu_result_val,
                                        lsb_result, lsb_result_rob_pos, lsb_result_val);
               end
            end

            if (pick_found) begin
               alu_en                 <= 1'b1;
               alu_opcode             <= entries[pick_idx].opcode;
               alu_funct3             <= entries[pick_idx].funct3;
               alu_funct7             <= entries[pick_idx].funct7;
               alu_val1               <= entries[pick_idx].src1.val;
               alu_val2               <= entries[pick_idx].src2.val;
               alu_imm                <= entries[pick_idx].imm;
               alu_pc                 <= entries[pick_idx].pc;
               alu_rob_pos            <= entries[pick_idx].rob_pos;
               entries[pick_idx].busy <= 1'b0;
            end else begin
               alu_en <= 1'b0;
            end

            if (issue && free_found) begin
               entries[free_idx] <= issue_entry;
            end
         end
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_reservation_station
//
// Directed self-checking bench for reservation_station. Inputs are driven
// and outputs sampled on the falling edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_reservation_station;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        rollback;
   logic        issue;
   logic [6:0]  issue_opcode;
   logic [2:0]  issue_funct3;
   logic        issue_funct7;
   logic        issue_rs1_rdy;
   logic [31:0] issue_rs1_val;
   logic [3:0]  issue_rs1_rob;
   logic        issue_rs2_rdy;
   logic [31:0] issue_rs2_val;
   logic [3:0]  issue_rs2_rob;
   logic [31:0] issue_imm;
   logic [31:0] issue_pc;
   logic [3:0]  issue_rob_pos;
   logic        rs_full;
   logic        alu_result;
   logic [3:0]  alu_result_rob_pos;
   logic [31:0] alu_result_val;
   logic        lsb_result;
   logic [3:0]  lsb_result_rob_pos;
   logic [31:0] lsb_result_val;
   logic        alu_en;
   logic [6:0]  alu_opcode;
   logic [2:0]  alu_funct3;
   logic        alu_funct7;
   logic [31:0] alu_val1;
   logic [31:0] alu_val2;
   logic [31:0] alu_imm;
   logic [31:0] alu_pc;
   logic [3:0]  alu_rob_pos;

   int checks   = 0;
   int failures = 0;

   reservation_station dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .issue(issue), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
      .issue_funct7(issue_funct7),
      .issue_rs1_rdy(issue_rs1_rdy), .issue_rs1_val(issue_rs1_val), .issue_rs1_rob(issue_rs1_rob),
      .issue_rs2_rdy(issue_rs2_rdy), .issue_rs2_val(issue_rs2_val), .issue_rs2_rob(issue_rs2_rob),
      .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_pos(issue_rob_pos),
      .rs_full(rs_full),
      .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos), .alu_result_val(alu_result_val),
      .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val),
      .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
      .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
      .alu_rob_pos(alu_rob_pos)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Issuing into a full station is a protocol error; flag it if this bench
   // ever does it (it would mean rs_full reported full when it should not).
   always @(posedge clk) begin
      if (rst && rdy && !rollback && issue && rs_full) begin
         failures++;
         $display("[TB] FAIL protocol_issue_while_full actual rs_full=%0b required=0", rs_full);
      end
   end

   task automatic set_idle();
      issue         = 1'b0;
      issue_opcode  = '0;
      issue_funct3  = '0;
      issue_funct7  = 1'b0;
      issue_rs1_rdy = 1'b0;
      issue_rs1_val = '0;
      issue_rs1_rob = '0;
      issue_rs2_rdy = 1'b0;
      issue_rs2_val = '0;
      issue_rs2_rob = '0;
      issue_imm     = '0;
      issue_pc      = '0;
      issue_rob_pos = '0;
      alu_result    = 1'b0;
      alu_result_rob_pos = '0;
      alu_result_val     = '0;
      lsb_result    = 1'b0;
      lsb_result_rob_pos = '0;
      lsb_result_val     = '0;
      rollback      = 1'b0;
   endtask

   // Present one instruction (ADD opcode) on the issue port.
   task automatic drive_issue(input logic r1, input logic [31:0] v1, input logic [3:0] q1,
                              input logic r2, input logic [31:0] v2, input logic [3:0] q2,
                              input logic [3:0] rob);
      issue         = 1'b1;
      issue_opcode  = 7'b0110011;
      issue_funct3  = 3'd0;
      issue_funct7  = 1'b0;
      issue_rs1_rdy = r1;
      issue_rs1_val = v1;
      issue_rs1_rob = q1;
      issue_rs2_rdy = r2;
      issue_rs2_val = v2;
      issue_rs2_rob = q2;
      issue_imm     = 32'h0000_0040;
      issue_pc      = 32'h0000_1000 + {28'd0, rob};
      issue_rob_pos = rob;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (alu_en !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_alu_en actual=%0b required=0", alu_en);
      end
      checks++;
      if (rs_full !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_rs_full actual=%0b required=0", rs_full);
      end
      checks++;
      if (alu_val1 !== 32'd0 || alu_rob_pos !== 4'd0) begin
         failures++; $display("[TB] FAIL reset_alu_out actual val1=%0h rob=%0d required 0/0", alu_val1, alu_rob_pos);
      end
      rst = 1'b1;
   endtask

   task automatic test_ready_issue();
      drive_issue(1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
      checks++;
      if (rs_full !== 1'b0) begin
         failures++; $display("[TB] FAIL ready_rs_full actual=%0b required=0", rs_full);
      end
      @(negedge clk);
      set_idle();
      checks++;
      if (alu_en !== 1'b0) begin
         failures++; $display("[TB] FAIL ready_early_dispatch actual=%0b required=0", alu_en);
      end
      @(negedge clk);
      checks++;
      if (alu_en !== 1'b1 || alu_val1 !== 32'd5 || alu_val2 !== 32'd7 || alu_rob_pos !== 4'd3
          || alu_opcode !== 7'b0110011 || alu_pc !== 32'h1003 || alu_imm !== 32'h40) begin
         failures++;
         $display("[TB] FAIL ready_dispatch actual en=%0b v1=%0h v2=%0h rob=%0d op=%0h pc=%0h required 1/5/7/3/33/1003",
                  alu_en, alu_val1, alu_val2, alu_rob_pos, alu_opcode, alu_pc);
      end
      @(negedge clk);
      checks++;
      if (alu_en !== 1'b0) begin
         failures++; $display("[TB] FAIL ready_single_pulse actual=%0b required=0", alu_en);
      end
   endtask

   task automatic test_wakeup();
      drive_issue(1'b0, 32'd0, 4'd9, 1'b1, 32'd2, 4'd0, 4'd5);
      @(negedge clk);
      set_idle();
      alu_result = 1'b1; alu_result_rob_pos = 4'd9; alu_result_val = 32'h10;
      @(negedge clk);
      set_idle();
      checks++;
      if (alu_en !== 1'b0) begin
         failures++; $display("[TB] FAIL wakeup_early_dispatch actual=%0b required=0", alu_en);
      end
      @(negedge clk);
      checks++;
      if (alu_en !== 1'b1 || alu_val1 !== 32'h10 || alu_val2 !== 32'd2 || alu_rob_pos !== 4'd5) begin
         failures++;
         $display("[TB] FAIL wakeup_dispatch actual en=%0b v1=%0h v2=%0h rob=%0d required 1/10/2/5",
                  alu_en, alu_val1, alu_val2, alu_rob_pos);
      end
      @(negedge clk);
   endtask

   task automatic test_bypass();
      drive_issue(1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd4, 4'd6);
      lsb_result = 1'b1; lsb_result_rob_pos = 4'd4; lsb_result_val = 32'hAB;
      @(negedge clk);
      set_idle();
      @(negedge clk);
      checks++;
      if (alu_en !== 1'b1 || alu_val1 !== 32'd1 || alu_val2 !== 32'hAB || alu_rob_pos !== 4'd6) begin
         failures++;
         $display("[TB] FAIL bypass_dispatch actual en=%0b v1=%0h v2=%0h rob=%0d required 1/1/ab/6",
                  alu_en, alu_val1, alu_val2, alu_rob_pos);
      end
      @(negedge clk);
   endtask

   task automatic test_fill();
      int bad_order = 0;
      for (int i = 0; i < 16; i++) begin
         drive_issue(1'b0, 32'd0, 4'd1, 1'b1, 32'(i), 4'd0, 4'(i));
         @(negedge clk);
      end
      set_idle();
      checks++;
      if (rs_full !== 1'b1 || alu_en !== 1'b0) begin
         failures++; $display("[TB] FAIL fill_full actual full=%0b en=%0b required 1/0", rs_full, alu_en);
      end
      alu_result = 1'b1; alu_result_rob_pos = 4'd1; alu_result_val = 32'h100;
      @(negedge clk);
      set_idle();
      checks++;
      if (alu_en !== 1'b0 || rs_full !== 1'b1) begin
         failures++; $display("[TB] FAIL fill_wakeup_cycle actual en=%0b full=%0b required 0/1", alu_en, rs_full);
      end
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (alu_en !== 1'b1 || alu_rob_pos !== 4'(k) || alu_val2 !== 32'(k) || alu_val1 !== 32'h100) begin
            bad_order++;
            $display("[TB] FAIL fill_dispatch_%0d actual en=%0b rob=%0d v1=%0h v2=%0h required 1/%0d/100/%0d",
                     k, alu_en, alu_rob_pos, alu_val1, alu_val2, k, k);
         end
         if (k == 0) begin
            checks++;
            if (rs_full !== 1'b0) begin
               failures++; $display("[TB] FAIL fill_full_drop actual=%0b required=0", rs_full);
            end
         end
      end
      checks++;
      if (bad_order != 0) failures++;
      @(negedge clk);
      checks++;
      if (alu_en !== 1'b0) begin
         failures++; $display("[TB] FAIL fill_drain_end actual=%0b required=0", alu_en);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 4; i++) begin
         drive_issue(1'b0, 32'd0, 4'd2, 1'b1, 32'h20 + 32'(i), 4'd0, 4'd8 + 4'(i));
         @(negedge clk);
      end
      set_idle();
      alu_result = 1'b1; alu_result_rob_pos = 4'd2; alu_result_val = 32'h55;
      @(negedge clk);
      set_idle();
      @(negedge clk);
      rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (alu_en !== 1'b1 || alu_rob_pos !== 4'd8 || alu_val2 !== 32'h20) begin
            failures++;
            $display("[TB] FAIL stall_hold_%0d actual en=%0b rob=%0d v2=%0h required 1/8/20",
                     c, alu_en, alu_rob_pos, alu_val2);
         end
      end
      rdy = 1'b1;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (alu_en !== 1'b1 || alu_rob_pos !== 4'd8 + 4'(k) || alu_val2 !== 32'h20 + 32'(k)
             || alu_val1 !== 32'h55) begin
            failures++;
            $display("[TB] FAIL stall_resume_%0d actual en=%0b rob=%0d v2=%0h required 1/%0d/%0h",
                     k, alu_en, alu_rob_pos, alu_val2, 8 + k, 32 + k);
         end
      end
      @(negedge clk);
      checks++;
      if (alu_en !== 1'b0) begin
         failures++; $display("[TB] FAIL stall_no_duplicate actual=%0b required=0", alu_en);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         drive_issue(1'b1, 32'(i), 4'd0, 1'b1, 32'd0, 4'd0, 4'd12 + 4'(i));
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (alu_en !== 1'b1 || alu_rob_pos !== 4'd11 + 4'(i) || alu_val1 !== 32'(i - 1)) begin
               failures++;
               $display("[TB] FAIL b2b_%0d actual en=%0b rob=%0d required 1/%0d", i, alu_en, alu_rob_pos, 11 + i);
            end
         end
      end
      set_idle();
      @(negedge clk);
      checks++;
      if (alu_en !== 1'b1 || alu_rob_pos !== 4'd15) begin
         failures++; $display("[TB] FAIL b2b_last actual en=%0b rob=%0d required 1/15", alu_en, alu_rob_pos);
      end
      @(negedge clk);
   endtask

   task automatic test_rollback();
      for (int i = 0; i < 8; i++) begin
         drive_issue(1'b0, 32'd0, 4'd3, 1'b1, 32'd0, 4'd0, 4'(i));
         @(negedge clk);
      end
      drive_issue(1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0, 4'd14);
      rollback = 1'b1;
      @(negedge clk);
      set_idle();
      checks++;
      if (alu_en !== 1'b0 || rs_full !== 1'b0) begin
         failures++; $display("[TB] FAIL rollback_state actual en=%0b full=%0b required 0/0", alu_en, rs_full);
      end
      alu_result = 1'b1; alu_result_rob_pos = 4'd3; alu_result_val = 32'h77;
      @(negedge clk);
      set_idle();
      checks++;
      if (alu_en !== 1'b0) begin
         failures++; $display("[TB] FAIL rollback_issue_discard actual=%0b required=0", alu_en);
      end
      @(negedge clk);
      checks++;
      if (alu_en !== 1'b0) begin
         failures++; $display("[TB] FAIL rollback_entries_cleared actual=%0b required=0", alu_en);
      end
   endtask

   task automatic test_async_reset();
      drive_issue(1'b1, 32'h33, 4'd0, 1'b1, 32'h44, 4'd0, 4'd2);
      @(negedge clk);
      set_idle();
      @(negedge clk);
      checks++;
      if (alu_en !== 1'b1 || alu_val1 !== 32'h33) begin
         failures++; $display("[TB] FAIL async_pre actual en=%0b v1=%0h required 1/33", alu_en, alu_val1);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (alu_en !== 1'b0 || alu_val1 !== 32'd0) begin
         failures++; $display("[TB] FAIL async_reset actual en=%0b v1=%0h required 0/0", alu_en, alu_val1);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (alu_en !== 1'b0 || rs_full !== 1'b0) begin
         failures++; $display("[TB] FAIL async_after actual en=%0b full=%0b required 0/0", alu_en, rs_full);
      end
   endtask

   // Test sequence.
   initial begin
      rst = 1'b0;
      rdy = 1'b1;
      set_idle();
      test_reset();
      test_ready_issue();
      test_wakeup();
      test_bypass();
      test_fill();
      test_stall();
      test_back_to_back();
      test_rollback();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
